des_region_sequencer: RTL and testbench

// Initiator side of the des_block start/valid protocol. Walks a range of 16-bit regions, driving one des_block
// per region: present region_select, hold start, wait for valid, capture counter, release start.

---
 rtl/des_region_sequencer_if.sv | 33 +++
 rtl/des_region_sequencer.sv | 176 +++++++++++++++++
 tb/tb_des_region_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/des_region_sequencer_if.sv
// ----------------------------------------------------------------------------
// des_region_sequencer_if
// Purpose : start/valid handshake bundle between the region sequencer
//           (initiator) and a single des_block (target).
// Signals : start          - initiator holds high while a region is running
//           region_select  - region index, stable while start is high
//           counter        - des_block mask-hit count for the region
//           valid          - des_block result ready; falls after start drops
// Modports: master (sequencer side), slave (des_block side)
// ----------------------------------------------------------------------------
interface des_region_sequencer_if #(
    parameter int unsigned REGION_W = 16,
    parameter int unsigned CNT_W    = 48
) ();
    logic                start;
    logic [REGION_W-1:0] region_select;
    logic [CNT_W-1:0]    counter;
    logic                valid;

    modport master (
        output start,
        output region_select,
        input  counter,
        input  valid
    );

    modport slave (
        input  start,
        input  region_select,
        output counter,
        output valid
    );
endinterface

// File: rtl/des_region_sequencer.sv
// ----------------------------------------------------------------------------
// des_region_sequencer
// Purpose : walks an inclusive (possibly wrapping) range of regions, running
//           one des_block job per region over the start/valid handshake.
//           Streams each per-region count and accumulates a grand total.
// Ports   : i_clk, i_rst_n           clock, synchronous active-low reset
//           i_run                    high = sweep, low = abort / return idle
//           i_first_region/_last     range bounds, sampled when leaving idle
//           blk_if (master)          handshake to des_block
//           o_res_valid/_region/_count  one-cycle result pulse + payload
//           o_total                  running sum of captured counts
//           o_regions_done           regions completed in this sweep
//           o_busy, o_done           status
// ----------------------------------------------------------------------------
module des_region_sequencer #(
    parameter int unsigned REGION_W = 16,
    parameter int unsigned CNT_W    = 48,
    parameter int unsigned ACC_W    = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_run,
    input  logic [REGION_W-1:0]   i_first_region,
    input  logic [REGION_W-1:0]   i_last_region,
    des_region_sequencer_if.master blk_if,
    output logic                  o_res_valid,
    output logic [REGION_W-1:0]   o_res_region,
    output logic [CNT_W-1:0]      o_res_count,
    output logic [ACC_W-1:0]      o_total,
    output logic [REGION_W:0]     o_regions_done,
    output logic                  o_busy,
    output logic                  o_done
);

    // The accumulator must hold 2^REGION_W maximal counts without overflow.
    if (ACC_W < CNT_W + REGION_W) begin : g_acc_w_check
        $error("ACC_W too small for CNT_W + REGION_W");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitValid,
        StRelease,
        StDone,
        StAbort
    } state_e;

    state_e              r_state,        w_state_d;
    logic [REGION_W-1:0] r_cur,          w_cur_d;
    logic [REGION_W-1:0] r_last,         w_last_d;
    logic                r_blk_start,    w_blk_start_d;
    logic [REGION_W-1:0] r_blk_sel,      w_blk_sel_d;
    logic                r_res_valid,    w_res_valid_d;
    logic [REGION_W-1:0] r_res_region,   w_res_region_d;
    logic [CNT_W-1:0]    r_res_count,    w_res_count_d;
    logic [ACC_W-1:0]    r_total,        w_total_d;
    logic [REGION_W:0]   r_regions_done, w_regions_done_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_cur          <= '0;
            r_last         <= '0;
            r_blk_start    <= 1'b0;
            r_blk_sel      <= '0;
            r_res_valid    <= 1'b0;
            r_res_region   <= '0;
            r_res_count    <= '0;
            r_total        <= '0;
            r_regions_done <= '0;
        end else begin
            r_state        <= w_state_d;
            r_cur          <= w_cur_d;
            r_last         <= w_last_d;
            r_blk_start    <= w_blk_start_d;
            r_blk_sel      <= w_blk_sel_d;
            r_res_valid    <= w_res_valid_d;
            r_res_region   <= w_res_region_d;
            r_res_count    <= w_res_count_d;
            r_total        <= w_total_d;
            r_regions_done <= w_regions_done_d;
        end
    end

    always_comb begin
        w_state_d        = r_state;
        w_cur_d          = r_cur;
        w_last_d         = r_last;
        w_blk_start_d    = r_blk_start;
        w_blk_sel_d      = r_blk_sel;
        w_res_valid_d    = 1'b0;
        w_res_region_d   = r_res_region;
        w_res_count_d    = r_res_count;
        w_total_d        = r_total;
        w_regions_done_d = r_regions_done;

        unique case (r_state)
            StIdle: begin
                if (i_run) begin
                    w_cur_d          = i_first_region;
                    w_last_d         = i_last_region;
                    w_total_d        = '0;
                    w_regions_done_d = '0;
                    w_state_d        = StLaunch;
                end
            end
            StLaunch: begin
                if (!i_run) begin
                    w_blk_start_d = 1'b0;
                    w_state_d     = StAbort;
                end else begin
                    // Select and start move together, so select is stable for the whole job.
                    w_blk_sel_d   = r_cur;
                    w_blk_start_d = 1'b1;
                    w_state_d     = StWaitValid;
                end
            end
            StWaitValid: begin
                if (!i_run) begin
                    // Abort beats a coincident valid: nothing is captured.
                    w_blk_start_d = 1'b0;
                    w_state_d     = StAbort;
                end else if (blk_if.valid) begin
                    // Capture while start is still high; des_block clears once it drops.
                    w_res_count_d    = blk_if.counter;
                    w_res_region_d   = r_cur;
                    w_res_valid_d    = 1'b1;
                    w_total_d        = r_total + ACC_W'(blk_if.counter);
                    w_regions_done_d = r_regions_done + (REGION_W + 1)'(1);
                    w_blk_start_d    = 1'b0;
                    w_state_d        = StRelease;
                end
            end
            StRelease: begin
                if (!i_run) begin
                    w_state_d = StAbort;
                end else if (!blk_if.valid) begin
                    if (r_cur == r_last) begin
                        w_state_d = StDone;
                    end else begin
                        // Natural wrap from all-ones back to zero.
                        w_cur_d   = r_cur + REGION_W'(1);
                        w_state_d = StLaunch;
                    end
                end
            end
            StDone: begin
                if (!i_run) begin
                    w_state_d = StIdle;
                end
            end
            StAbort: begin
                if (!blk_if.valid) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_blk_start_d = 1'b0;
                w_state_d     = StIdle;
            end
        endcase
    end

    assign blk_if.start         = r_blk_start;
    assign blk_if.region_select = r_blk_sel;

    assign o_res_valid    = r_res_valid;
    assign o_res_region   = r_res_region;
    assign o_res_count    = r_res_count;
    assign o_total        = r_total;
    assign o_regions_done = r_regions_done;
    assign o_busy         = (r_state != StIdle) && (r_state != StDone);
    assign o_done         = (r_state == StDone);

endmodule

// File: tb/tb_des_region_sequencer.sv
// ----------------------------------------------------------------------------
// tb_des_region_sequencer
// Self-checking bench: behavioural des_block model (valid LAT cycles after
// start, count = f(region)), scoreboard queue of expected results, and a
// handshake protocol monitor.
// ----------------------------------------------------------------------------
module tb_des_region_sequencer;

    localparam int unsigned REGION_W = 16;
    localparam int unsigned CNT_W    = 48;
    localparam int unsigned ACC_W    = 64;
    localparam int          LAT      = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                run;
    logic [REGION_W-1:0] first_region;
    logic [REGION_W-1:0] last_region;
    logic                res_valid;
    logic [REGION_W-1:0] res_region;
    logic [CNT_W-1:0]    res_count;
    logic [ACC_W-1:0]    total;
    logic [REGION_W:0]   regions_done;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    des_region_sequencer_if #(.REGION_W(REGION_W), .CNT_W(CNT_W)) u_blk_if ();

    des_region_sequencer #(
        .REGION_W(REGION_W),
        .CNT_W   (CNT_W),
        .ACC_W   (ACC_W)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_run         (run),
        .i_first_region(first_region),
        .i_last_region (last_region),
        .blk_if        (u_blk_if.master),
        .o_res_valid   (res_valid),
        .o_res_region  (res_region),
        .o_res_count   (res_count),
        .o_total       (total),
        .o_regions_done(regions_done),
        .o_busy        (busy),
        .o_done        (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- des_block model ----------------
    int cnt_mode = 0;
    int m_timer  = 0;

    function automatic logic [CNT_W-1:0] model_count(input logic [REGION_W-1:0] r);
        case (cnt_mode)
            0:       return 48'd100;
            1:       return (48'(r) + 48'd1) * 48'd10;
            2:       return 48'(r) * 48'd3 + 48'd7;
            default: return {CNT_W{1'b1}};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n || !u_blk_if.start) begin
            u_blk_if.valid   <= 1'b0;
            u_blk_if.counter <= '0;
            m_timer          <= 0;
        end else if (!u_blk_if.valid) begin
            if (m_timer == LAT - 1) begin
                u_blk_if.valid   <= 1'b1;
                u_blk_if.counter <= model_count(u_blk_if.region_select);
            end else begin
                m_timer <= m_timer + 1;
            end
        end
    end

    // ---------------- scoreboard + protocol monitor ----------------
    typedef struct {
        logic [REGION_W-1:0] region;
        logic [CNT_W-1:0]    count;
    } exp_t;

    exp_t                sb_q[$];
    exp_t                mon_e;
    logic                prev_start = 1'b0;
    logic                prev_valid = 1'b0;
    logic [REGION_W-1:0] prev_sel   = '0;

    always @(negedge clk) begin
        if (res_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_result", 64'(sb_q.size()), 64'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("res_region", 64'(res_region), 64'(mon_e.region));
                check_eq("res_count", 64'(res_count), 64'(mon_e.count));
            end
        end
        if (u_blk_if.start && prev_start) begin
            check_eq("sel_stable", 64'(u_blk_if.region_select), 64'(prev_sel));
        end
        if (u_blk_if.start && !prev_start) begin
            check_eq("start_rise_valid_low", 64'(prev_valid), 64'd0);
        end
        prev_start = u_blk_if.start;
        prev_valid = u_blk_if.valid;
        prev_sel   = u_blk_if.region_select;
    end

    // ---------------- stimulus ----------------
    task automatic run_sweep(input string name, input logic [REGION_W-1:0] first,
                             input logic [REGION_W-1:0] last, input int mode, input int n);
        logic [63:0]         exp_total;
        logic [REGION_W-1:0] r;
        exp_t                e;
        exp_total = '0;
        r         = first;
        cnt_mode  = mode;
        for (int k = 0; k < n; k++) begin
            e.region  = r;
            e.count   = model_count(r);
            sb_q.push_back(e);
            exp_total = exp_total + 64'(e.count);
            r         = r + 16'd1;
        end
        first_region = first;
        last_region  = last;
        run          = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
        check_eq({name, "_done"}, 64'(done), 64'd1);
        check_eq({name, "_total"}, total, exp_total);
        check_eq({name, "_regions_done"}, 64'(regions_done), 64'(n));
        check_eq({name, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
        check_eq({name, "_busy_in_done"}, 64'(busy), 64'd0);
        run = 1'b0;
        @(negedge clk);
        check_eq({name, "_done_falls"}, 64'(done), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        int  seen;
        bit  aborted;
        bit  started;
        rst_n        = 1'b0;
        run          = 1'b0;
        first_region = '0;
        last_region  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_start", 64'(u_blk_if.start), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_total", total, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep("single", 16'd5, 16'd5, 0, 1);
        run_sweep("four", 16'd0, 16'd3, 1, 4);
        run_sweep("wrap", 16'hFFFE, 16'h0001, 2, 4);
        run_sweep("maxcnt", 16'd10, 16'd13, 3, 4);
        check_eq("maxcnt_total_const", total, 64'h3_FFFF_FFFF_FFFC);

        // Reset mid-sweep while the first job is running.
        cnt_mode     = 1;
        first_region = 16'd7;
        last_region  = 16'd9;
        run          = 1'b1;
        started      = 1'b0;
        for (int i = 0; i < 50 && !started; i++) begin
            @(negedge clk);
            if (u_blk_if.start) started = 1'b1;
        end
        check_eq("rst_mid_started", 64'(started), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rstm_start", 64'(u_blk_if.start), 64'd0);
        check_eq("rstm_sel", 64'(u_blk_if.region_select), 64'd0);
        check_eq("rstm_res_valid", 64'(res_valid), 64'd0);
        check_eq("rstm_res_region", 64'(res_region), 64'd0);
        check_eq("rstm_res_count", 64'(res_count), 64'd0);
        check_eq("rstm_total", total, 64'd0);
        check_eq("rstm_regions_done", 64'(regions_done), 64'd0);
        check_eq("rstm_busy", 64'(busy), 64'd0);
        check_eq("rstm_done", 64'(done), 64'd0);
        run   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Abort on the cycle valid arrives for region 1; region 0 completes.
        cnt_mode     = 1;
        sb_q.push_back('{16'd0, 48'd10});
        first_region = 16'd0;
        last_region  = 16'd3;
        run          = 1'b1;
        seen         = 0;
        aborted      = 1'b0;
        for (int i = 0; i < 500 && !aborted; i++) begin
            @(negedge clk);
            if (u_blk_if.start && u_blk_if.valid) begin
                seen++;
                if (seen == 2) begin
                    run     = 1'b0;
                    aborted = 1'b1;
                end
            end
        end
        check_eq("abort_reached", 64'(aborted), 64'd1);
        @(negedge clk);
        check_eq("abort_start_low", 64'(u_blk_if.start), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd1);
        check_eq("abort_done", 64'(done), 64'd0);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        check_eq("abort_idle", 64'(busy), 64'd0);
        check_eq("abort_done_idle", 64'(done), 64'd0);
        check_eq("abort_total", total, 64'd10);
        check_eq("abort_regions_done", 64'(regions_done), 64'd1);
        check_eq("abort_sb_drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();

        run_sweep("after_abort", 16'd0, 16'd3, 1, 4);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
